// File: rtl/ctrl_pkg.sv
// Shared definitions for the accumulator-machine controller: FSM states,
// opcodes, ALU and write-back encodings, and the control word layout.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_FETCH2  = 4'd3,
    S_LD_MEM  = 4'd4,
    S_ST_MEM  = 4'd5,
    S_JMP     = 4'd6,
    S_ALUM_EX = 4'd7,
    S_ALU_WB  = 4'd8,
    S_RR_EX   = 4'd9,
    S_RR_WB   = 4'd10,
    S_MOV     = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  localparam logic [3:0] OP_LD   = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0010;
  localparam logic [3:0] OP_JMP  = 4'b0100;
  localparam logic [3:0] OP_ALUM = 4'b0110;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_AND  = 4'b1010;
  localparam logic [3:0] OP_NOT  = 4'b1011;
  localparam logic [3:0] OP_MOV  = 4'b1100;
  localparam logic [3:0] OP_NOP  = 4'b1101;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] ROM_MEM = 2'b00;
  localparam logic [1:0] ROM_ALU = 2'b01;
  localparam logic [1:0] ROM_ACJ = 2'b10;

  typedef struct packed {
    logic       halt;
    logic       pc_write;
    logic       jmp;
    logic       mem_read;
    logic       mem_write;
    logic       iod;
    logic       ld_di;
    logic       lir;
    logic       ltr;
    logic       reg_sel;
    logic       b_sel;
    logic       reg_write;
    logic       pc_sel;
    logic       ld_c;
    logic       ld_n;
    logic       ld_z;
    logic       write_sel;
    logic [1:0] alu_op;
    logic [1:0] reg_or_mem;
  } ctrl_t;

endpackage

// File: rtl/ctrl_outdec.sv
// Combinational state-to-control decoder. Every field defaults to 0, so
// IDLE and any illegal state code yield an all-zero control word.
module ctrl_outdec
  import ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [1:0] i_rr_aluop,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.lir      = 1'b1;
        o_ctrl.pc_write = 1'b1;
      end
      S_DECODE: o_ctrl.ld_di = 1'b1;
      S_FETCH2: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.ltr      = 1'b1;
        o_ctrl.pc_write = 1'b1;
      end
      S_LD_MEM: begin
        o_ctrl.iod        = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_or_mem = ROM_MEM;
      end
      S_ST_MEM: begin
        o_ctrl.iod       = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      S_JMP: begin
        o_ctrl.jmp    = 1'b1;
        o_ctrl.pc_sel = 1'b1;
      end
      S_ALUM_EX: begin
        o_ctrl.iod      = 1'b1;
        o_ctrl.mem_read = 1'b1;
        o_ctrl.b_sel    = 1'b1;
        o_ctrl.alu_op   = ALU_ADD;
        o_ctrl.ld_c     = 1'b1;
        o_ctrl.ld_n     = 1'b1;
        o_ctrl.ld_z     = 1'b1;
      end
      S_ALU_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_or_mem = ROM_ALU;
      end
      // The only state whose outputs depend on an input
      S_RR_EX: begin
        o_ctrl.reg_sel = 1'b1;
        o_ctrl.alu_op  = i_rr_aluop;
        o_ctrl.ld_c    = 1'b1;
        o_ctrl.ld_n    = 1'b1;
        o_ctrl.ld_z    = 1'b1;
      end
      S_RR_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_or_mem = ROM_ALU;
        o_ctrl.write_sel  = 1'b1;
      end
      S_MOV: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_or_mem = ROM_ACJ;
        o_ctrl.write_sel  = 1'b1;
      end
      S_HALT:  o_ctrl.halt = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/controller.sv
// Multi-cycle Moore controller for the 8-bit accumulator datapath: state
// register and next-state logic; output decoding lives in ctrl_outdec.
module controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] OpCode,
  output logic       Halt,
  output logic       PCWrite,
  output logic       Jmp,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IOD,
  output logic       LdDI,
  output logic       LIR,
  output logic       LTR,
  output logic       RegSel,
  output logic       BSel,
  output logic       RegWrite,
  output logic       PcSel,
  output logic       LdC,
  output logic       LdN,
  output logic       LdZ,
  output logic       WriteSel,
  output logic [1:0] AluOp,
  output logic [1:0] RegOrMem
);

  state_t r_state;
  state_t w_next;
  logic   r_rst_hold;
  ctrl_t  w_ctrl;

  // r_rst_hold keeps IDLE for one extra edge after reset release so the
  // first FETCH lands on the second rising edge with rst low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rst_hold <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_rst_hold <= 1'b0;
    end
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = r_rst_hold ? S_IDLE : S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        casez (OpCode)
          4'b0???: w_next = S_FETCH2;
          4'b10??: w_next = S_RR_EX;
          OP_MOV:  w_next = S_MOV;
          OP_HLT:  w_next = S_HALT;
          default: w_next = S_FETCH;
        endcase
      end
      S_FETCH2: begin
        case (OpCode[3:1])
          OP_LD[3:1]:   w_next = S_LD_MEM;
          OP_ST[3:1]:   w_next = S_ST_MEM;
          OP_JMP[3:1]:  w_next = S_JMP;
          OP_ALUM[3:1]: w_next = S_ALUM_EX;
          default:      w_next = S_FETCH;
        endcase
      end
      S_LD_MEM:  w_next = S_FETCH;
      S_ST_MEM:  w_next = S_FETCH;
      S_JMP:     w_next = S_FETCH;
      S_ALUM_EX: w_next = S_ALU_WB;
      S_ALU_WB:  w_next = S_FETCH;
      S_RR_EX:   w_next = S_RR_WB;
      S_RR_WB:   w_next = S_FETCH;
      S_MOV:     w_next = S_FETCH;
      S_HALT:    w_next = S_HALT;
      default:   w_next = S_IDLE;
    endcase
  end

  ctrl_outdec u_outdec (
    .i_state    (r_state),
    .i_rr_aluop (OpCode[1:0]),
    .o_ctrl     (w_ctrl)
  );

  assign Halt     = w_ctrl.halt;
  assign PCWrite  = w_ctrl.pc_write;
  assign Jmp      = w_ctrl.jmp;
  assign MemRead  = w_ctrl.mem_read;
  assign MemWrite = w_ctrl.mem_write;
  assign IOD      = w_ctrl.iod;
  assign LdDI     = w_ctrl.ld_di;
  assign LIR      = w_ctrl.lir;
  assign LTR      = w_ctrl.ltr;
  assign RegSel   = w_ctrl.reg_sel;
  assign BSel     = w_ctrl.b_sel;
  assign RegWrite = w_ctrl.reg_write;
  assign PcSel    = w_ctrl.pc_sel;
  assign LdC      = w_ctrl.ld_c;
  assign LdN      = w_ctrl.ld_n;
  assign LdZ      = w_ctrl.ld_z;
  assign WriteSel = w_ctrl.write_sel;
  assign AluOp    = w_ctrl.alu_op;
  assign RegOrMem = w_ctrl.reg_or_mem;

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 SHALL have no parameters; widths are fixed by the 8-bit accumulator datapath.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 OpCode  input  4  IR[7:4] from the datapath; stable except in the cycle after LIR.
REQ-005 Halt  output  1  freezes PC.
REQ-006 PCWrite  output  1  unconditional PC load.
REQ-007 Jmp  output  1  conditional PC load; the condition is evaluated in the datapath from DI[2:1] and the flags.
REQ-008 MemRead  output  1  memory read strobe.
REQ-009 MemWrite  output  1  memory write strobe.
REQ-010 IOD  output  1  address select: 0=PC, 1=TR.
REQ-011 LdDI, LIR, LTR  output  1 each  load the DI, IR and TR registers respectively.
REQ-012 RegSel  output  1  read-port-1 select: 0=DI[4:3], 1=IR[3:2].
REQ-013 BSel  output  1  ALU B operand select: 0=Acj, 1=MemOut.
REQ-014 RegWrite  output  1  register-file write enable.
REQ-015 PcSel  output  1  PC source select: 0=PC+1, 1=TR.
REQ-016 LdC, LdN, LdZ  output  1 each  flag load enables.
REQ-017 WriteSel  output  1  write-register select: 0=DI[4:3], 1=IR[3:2].
REQ-018 AluOp  output  2  ALU operation: 00 add, 01 sub, 10 and, 11 not.
REQ-019 RegOrMem  output  2  write-data select: 00=MemOut, 01=AluOut, 10=Acj.

Function
REQ-020 SHALL be a Moore FSM: outputs depend on the state only, except AluOp in RR_EX, which equals OpCode[1:0]. Every output not listed for a state SHALL be 0.
REQ-021 States: IDLE, FETCH, DECODE, FETCH2, LD_MEM, ST_MEM, JMP, ALUM_EX, ALU_WB, RR_EX, RR_WB, MOV, HALT.
REQ-022 IDLE: all outputs 0. Next state is FETCH.
REQ-023 FETCH: MemRead=1, IOD=0, LIR=1, PCWrite=1, PcSel=0. Next state is DECODE.
REQ-024 DECODE: LdDI=1. Next state by OpCode:
- 000x, 001x, 010x, 011x: FETCH2.
- 1000-1011: RR_EX.
- 1100: MOV.
- 1101, 1110: FETCH (NOP).
- 1111: HALT.
REQ-025 FETCH2: MemRead=1, IOD=0, LTR=1, PCWrite=1, PcSel=0. Next state by OpCode[3:1]:
- 000: LD_MEM.
- 001: ST_MEM.
- 010: JMP.
- 011: ALUM_EX.
REQ-026 LD_MEM: IOD=1, MemRead=1, RegWrite=1, RegOrMem=00, WriteSel=0. Next state is FETCH.
REQ-027 ST_MEM: IOD=1, MemWrite=1, RegSel=0. Next state is FETCH.
REQ-028 JMP: Jmp=1, PcSel=1. Next state is FETCH.
REQ-029 ALUM_EX: IOD=1, MemRead=1, BSel=1, RegSel=0, AluOp=00, LdC=LdN=LdZ=1. Next state is ALU_WB.
REQ-030 ALU_WB: RegWrite=1, RegOrMem=01, WriteSel=0. Next state is FETCH.
REQ-031 RR_EX: RegSel=1, BSel=0, AluOp=OpCode[1:0], LdC=LdN=LdZ=1. Next state is RR_WB.
REQ-032 RR_WB: RegWrite=1, RegOrMem=01, WriteSel=1. Next state is FETCH.
REQ-033 MOV: RegWrite=1, RegOrMem=10, WriteSel=1. Next state is FETCH.
REQ-034 HALT: Halt=1, all strobes 0. Stays in HALT until reset.
REQ-035 Cycles per instruction, counted FETCH through the last state:
- 2: NOP, HLT.
- 3: MOV.
- 4: LD, ST, JMP, RR.
- 5: ALUM.
REQ-036 MemRead and MemWrite SHALL never be 1 in the same cycle. RegWrite and MemWrite SHALL never be 1 in the same cycle.
REQ-037 Any unreachable state encoding SHALL return to IDLE on the next edge.

Reset
REQ-038 rst=1 SHALL force IDLE asynchronously, driving every output to 0 (AluOp=00, RegOrMem=00) while rst is held.
REQ-039 rst asserted mid-instruction SHALL abort the instruction. The first FETCH SHALL occur on the second rising edge after rst deasserts.

Structure
REQ-040 Package ctrl_pkg SHALL hold the following, shared with the datapath bench:
- the state enum;
- the opcode constants (LD, ST, JMP, ALUM, ADD, SUB, AND, NOT, MOV, NOP, HLT);
- the AluOp encodings;
- the RegOrMem encodings.
REQ-041 One sub-module, ctrl_outdec (a combinational state-to-control decoder), SHALL be used. The state register and next-state logic SHALL stay in controller.

Verification
REQ-042 Reset: rst=1 mid-ALU_WB, released, OpCode=1101 -> all outputs 0 for one cycle, then FETCH (MemRead=LIR=PCWrite=1), then DECODE.
REQ-043 LD: OpCode=0000 -> FETCH, DECODE, FETCH2 (LTR=1), LD_MEM (IOD=1, RegWrite=1, RegOrMem=00), then FETCH on cycle 5.
REQ-044 RR SUB: OpCode=1001 -> RR_EX with AluOp=01 and LdC=LdN=LdZ=1, then RR_WB with WriteSel=1 and RegOrMem=01; 4 cycles total.
REQ-045 ST then JMP: OpCode=0010 then 0100 -> MemWrite=1 with IOD=1 exactly once, then Jmp=1 with PcSel=1 exactly once; PCWrite=0 in the JMP state.
REQ-046 HLT: OpCode=1111 -> Halt=1 held for 20 cycles with no strobes asserted; rst then returns the FSM to IDLE.
REQ-047 Random opcode stream of 1000 instructions -> the assertions of REQ-036 never fire, and the cycle counts match REQ-035.
